// File: rtl/mem_access_ctrl.sv
// Data-memory initiator for the multi-cycle CPU: turns byte/half/word/dword requests into
// aligned dword accesses, with read-modify-write for narrow stores and load lane extraction.
//   state | meaning
//   IDLE  | ready for a request; error checks done at accept
//   RD    | memory read of the addressed dword (load result or old data for merge)
//   WR    | write of the merged dword
//   DONE  | one-cycle response pulse
module mem_access_ctrl #(
    parameter int ADDR_W    = 64,
    parameter int MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [63:0]       mem_wd,
    input  logic [63:0]       mem_rd
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              misaligned, out_of_range, req_bad;
    logic              we_q, signed_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q, old_q;
    logic [5:0]        lane_sh;
    logic [63:0]       shifted, load_ext, lane_mask, merged;
    logic [ADDR_W-1:0] word_idx;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0: misaligned = 1'b0;
            2'd1: misaligned = req_addr[0];
            2'd2: misaligned = |req_addr[1:0];
            2'd3: misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign word_idx     = {3'b000, req_addr[ADDR_W-1:3]};
    assign out_of_range = (word_idx >= ADDR_W'(MEM_WORDS));
    assign req_bad      = misaligned | out_of_range;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = req_bad ? DONE : RD;
                end
            end
            RD:      state_nxt = we_q ? WR : DONE;
            WR:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane handling: byte offset within the dword selects the shift for both load and merge.
    assign lane_sh = {addr_q[2:0], 3'b000};
    assign shifted = mem_rd >> lane_sh;

    always_comb begin
        load_ext  = 64'd0;
        lane_mask = 64'd0;
        case (size_q)
            2'd0: begin
                load_ext  = {{56{signed_q & shifted[7]}}, shifted[7:0]};
                lane_mask = 64'h0000_0000_0000_00FF;
            end
            2'd1: begin
                load_ext  = {{48{signed_q & shifted[15]}}, shifted[15:0]};
                lane_mask = 64'h0000_0000_0000_FFFF;
            end
            2'd2: begin
                load_ext  = {{32{signed_q & shifted[31]}}, shifted[31:0]};
                lane_mask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                load_ext  = shifted;
                lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        endcase
    end

    assign merged = (old_q & ~(lane_mask << lane_sh)) | ((wdata_q << lane_sh) & (lane_mask << lane_sh));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= 64'd0;
            old_q      <= 64'd0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q     <= req_we;
                signed_q <= req_signed;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                if (req_bad) begin
                    resp_rdata <= 64'd0;
                    resp_err   <= 1'b1;
                end
            end
            if (state == RD) begin
                old_q <= mem_rd;
                if (!we_q) begin
                    resp_rdata <= load_ext;
                    resp_err   <= 1'b0;
                end
            end
            if (state == WR) begin
                resp_rdata <= 64'd0;
                resp_err   <= 1'b0;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign mem_a      = (state == RD || state == WR) ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign mem_we     = (state == WR) && !reset;
    assign mem_wd     = (state == WR) ? merged : 64'd0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 64x64-bit behavioural data memory.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_signed;
    logic        req_ready;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_we;
    logic [63:0] resp_rdata, mem_a, mem_wd, mem_rd;

    logic [63:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [63:0] pl_data;

    int errors = 0;
    int checks = 0;

    int          r_lat, r_we_n, r_we_cyc;
    logic [63:0] r_rdata, r_we_a, r_we_wd, r_a1;
    logic        r_err, r_mem_act;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(64), .MEM_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_a[8:3]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[8:3]] <= mem_wd;
        else if (pl_en) mem[pl_idx] <= pl_data;
    end

    task automatic preload(input int idx, input logic [63:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = 6'(idx); pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [63:0] addr, input logic [63:0] wd);
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_issue got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        r_lat = 0; r_we_n = 0; r_we_cyc = 0; r_rdata = 'x; r_err = 1'bx;
        r_we_a = 0; r_we_wd = 0; r_a1 = 0; r_mem_act = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            if (i == 1) r_a1 = mem_a;
            if (mem_a !== 64'd0 || mem_we !== 1'b0) r_mem_act = 1'b1;
            if (mem_we === 1'b1) begin
                r_we_n++; r_we_cyc = i; r_we_a = mem_a; r_we_wd = mem_wd;
            end
            if (resp_valid === 1'b1) begin
                r_lat = i; r_rdata = resp_rdata; r_err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        checks++; if (mem_a !== 64'd0) begin errors++; $display("FAIL rst_mem_a got %h want 0", mem_a); end
        checks++; if (mem_wd !== 64'd0) begin errors++; $display("FAIL rst_mem_wd got %h want 0", mem_wd); end
        checks++; if (resp_rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", resp_err); end
    endtask

    task automatic test_load_dword;
        preload(2, 64'h1122_3344_5566_7788);
        issue(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL ld_dw_latency got %0d want 2", r_lat); end
        checks++; if (r_a1 !== 64'h10) begin errors++; $display("FAIL ld_dw_mem_a got %h want 10", r_a1); end
        checks++; if (r_rdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL ld_dw_rdata got %h want 1122334455667788", r_rdata); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL ld_dw_err got %b want 0", r_err); end
        checks++; if (r_we_n !== 0) begin errors++; $display("FAIL ld_dw_we_pulses got %0d want 0", r_we_n); end
    endtask

    task automatic test_load_byte;
        preload(2, 64'h8000_0000_0000_0000);
        issue(1'b0, 2'd0, 1'b1, 64'h17, 64'd0);
        checks++; if (r_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL ld_b_signed got %h want ffffffffffffff80", r_rdata); end
        issue(1'b0, 2'd0, 1'b0, 64'h17, 64'd0);
        checks++; if (r_rdata !== 64'h80) begin errors++; $display("FAIL ld_b_unsigned got %h want 80", r_rdata); end
    endtask

    task automatic test_store_half;
        preload(1, 64'd0);
        issue(1'b1, 2'd1, 1'b0, 64'h0A, 64'h0000_0000_0000_BEEF);
        checks++; if (r_we_n !== 1) begin errors++; $display("FAIL st_h_we_pulses got %0d want 1", r_we_n); end
        checks++; if (r_we_cyc !== 2) begin errors++; $display("FAIL st_h_we_cycle got %0d want 2", r_we_cyc); end
        checks++; if (r_we_a !== 64'h08) begin errors++; $display("FAIL st_h_mem_a got %h want 08", r_we_a); end
        checks++; if (r_we_wd !== 64'h0000_0000_BEEF_0000) begin errors++; $display("FAIL st_h_mem_wd got %h want 00000000beef0000", r_we_wd); end
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL st_h_latency got %0d want 3", r_lat); end
        checks++; if (r_rdata !== 64'd0 || r_err !== 1'b0) begin errors++; $display("FAIL st_h_resp got %h/%b want 0/0", r_rdata, r_err); end
        checks++; if (mem[1] !== 64'h0000_0000_BEEF_0000) begin errors++; $display("FAIL st_h_mem1 got %h want 00000000beef0000", mem[1]); end
    endtask

    task automatic test_store_merge;
        preload(3, 64'h1111_1111_1111_1111);
        issue(1'b1, 2'd0, 1'b0, 64'h1D, 64'h0000_0000_0000_77AB);
        checks++; if (mem[3] !== 64'h1111_AB11_1111_1111) begin errors++; $display("FAIL st_b_merge got %h want 1111ab1111111111", mem[3]); end
        preload(4, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(1'b1, 2'd3, 1'b0, 64'h20, 64'h0123_4567_89AB_CDEF);
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL st_dw_latency got %0d want 3", r_lat); end
        checks++; if (mem[4] !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL st_dw_mem got %h want 0123456789abcdef", mem[4]); end
        issue(1'b0, 2'd2, 1'b1, 64'h24, 64'd0);
        checks++; if (r_rdata !== 64'h0000_0000_0123_4567) begin errors++; $display("FAIL ld_w_signed_pos got %h want 0000000001234567", r_rdata); end
        issue(1'b0, 2'd1, 1'b1, 64'h22, 64'd0);
        checks++; if (r_rdata !== 64'hFFFF_FFFF_FFFF_89AB) begin errors++; $display("FAIL ld_h_signed_neg got %h want ffffffffffff89ab", r_rdata); end
    endtask

    task automatic test_errors;
        issue(1'b0, 2'd2, 1'b0, 64'h06, 64'd0);
        checks++; if (r_lat !== 1) begin errors++; $display("FAIL err_mis_latency got %0d want 1", r_lat); end
        checks++; if (r_err !== 1'b1 || r_rdata !== 64'd0) begin errors++; $display("FAIL err_mis_resp got %b/%h want 1/0", r_err, r_rdata); end
        checks++; if (r_mem_act !== 1'b0) begin errors++; $display("FAIL err_mis_mem_activity got %b want 0", r_mem_act); end
        issue(1'b0, 2'd3, 1'b0, 64'h200, 64'd0);
        checks++; if (r_err !== 1'b1 || r_lat !== 1) begin errors++; $display("FAIL err_range got err=%b lat=%0d want 1/1", r_err, r_lat); end
        issue(1'b1, 2'd1, 1'b0, 64'h201, 64'h1234);
        checks++; if (r_err !== 1'b1 || r_we_n !== 0) begin errors++; $display("FAIL err_store got err=%b we=%0d want 1/0", r_err, r_we_n); end
        issue(1'b0, 2'd3, 1'b0, 64'h1F8, 64'd0);
        checks++; if (r_err !== 1'b0 || r_lat !== 2) begin errors++; $display("FAIL last_word_ok got err=%b lat=%0d want 0/2", r_err, r_lat); end
    endtask

    task automatic test_reset_mid_write;
        int resp_seen;
        preload(5, 64'h5555_5555_5555_5555);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 64'h28; req_wdata = 64'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_wr_mem_we got %b want 0", mem_we); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_idle got ready=%b want 1", req_ready); end
        resp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid === 1'b1) resp_seen++;
            @(negedge clk);
            #1;
        end
        checks++; if (resp_seen !== 0) begin errors++; $display("FAIL rst_wr_resp got %0d pulses want 0", resp_seen); end
        checks++; if (mem[5] !== 64'h5555_5555_5555_5555) begin errors++; $display("FAIL rst_wr_mem got %h want 5555555555555555", mem[5]); end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0; pl_en = 1'b0; pl_idx = 6'd0; pl_data = 64'd0;
        for (int i = 0; i < 64; i++) mem[i] = 64'd0;
        test_reset;
        test_load_dword;
        test_load_byte;
        test_store_half;
        test_store_merge;
        test_errors;
        test_reset_mid_write;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
